// File: rtl/mcm_pkg.sv
// Shared constants, tap word type and output rounding for the MCM_1 tap scheduler.
package mcm_pkg;

    localparam int N_COEF = 42;
    localparam int ACC_W  = 18;
    localparam int PIX_W  = 8;

    localparam logic [6:0] COEF_TAB [0:N_COEF-1] = '{
        7'd64, 7'd63, 7'd62, 7'd60, 7'd58, 7'd57, 7'd56, 7'd55, 7'd54, 7'd53,
        7'd52, 7'd49, 7'd46, 7'd44, 7'd42, 7'd39, 7'd36, 7'd33, 7'd30, 7'd29,
        7'd28, 7'd24, 7'd20, 7'd18, 7'd16, 7'd15, 7'd14, 7'd12, 7'd10, 7'd7,
        7'd4,  7'd2,  7'd32, 7'd31, 7'd27, 7'd26, 7'd25, 7'd23, 7'd22, 7'd21,
        7'd19, 7'd17
    };

    typedef struct packed {
        logic [PIX_W-1:0] sample;
        logic [5:0]       cidx;
        logic             neg;
    } tap_t;

    // Round half up, arithmetic shift, then saturate to the pixel range.
    function automatic logic [PIX_W-1:0] round_clip(input logic signed [ACC_W-1:0] a,
                                                    input int sh);
        logic signed [ACC_W:0] t;
        t = {a[ACC_W-1], a} + (ACC_W+1)'(1 << (sh - 1));
        t = t >>> sh;
        if (t[ACC_W])
            return '0;
        else if (|t[ACC_W-1:PIX_W])
            return '1;
        else
            return t[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/mcm_1.sv
// MCM_1 constant-multiplier bank: every coefficient of COEF_TAB applied to one sample.
module mcm_1
    import mcm_pkg::*;
(
    input  logic [PIX_W-1:0] x,
    output logic [15:0]      y [0:N_COEF-1]
);

    for (genvar i = 0; i < N_COEF; i++) begin : g_y
        assign y[i] = 16'(x) * 16'(COEF_TAB[i]);
    end

endmodule

// File: rtl/mcm_sel.sv
// Product selector around the shared MCM_1 bank; indices past the table yield zero.
module mcm_sel
    import mcm_pkg::*;
(
    input  logic [PIX_W-1:0] x,
    input  logic [5:0]       cidx,
    output logic [15:0]      prod
);

    logic [15:0] y [0:N_COEF-1];

    mcm_1 u_mcm (
        .x (x),
        .y (y)
    );

    always_comb begin
        prod = '0;
        if (cidx < 6'(N_COEF))
            prod = y[cidx];
    end

endmodule

// File: rtl/mcm_tap_sched.sv
// Tap sequencer: accumulates NTAPS MCM_1 products per pixel, rounds, clips and emits.
// Define MCM_SCHED_PIPE_EN to register the selected product before the accumulator.
module mcm_tap_sched
    import mcm_pkg::*;
#(
    parameter int NTAPS = 4,
    parameter int SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_sample,
    input  logic [5:0]       in_cidx,
    input  logic             in_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             busy
);

    localparam int              CW   = (NTAPS > 2) ? 2 : 1;
    localparam logic [CW-1:0]   LAST = CW'(NTAPS - 1);

    tap_t                    tap;
    logic [15:0]             prod;
    logic                    accept, first, last;
    logic [CW-1:0]           tap_cnt;
    logic signed [ACC_W-1:0] sprod, acc, acc_next, a_prod;
    logic                    a_valid, a_first, a_last, stage_busy;

    assign tap = '{sample: in_sample, cidx: in_cidx, neg: in_neg};

    mcm_sel u_sel (
        .x    (tap.sample),
        .cidx (tap.cidx),
        .prod (prod)
    );

    assign sprod = tap.neg ? -$signed({2'b00, prod}) : $signed({2'b00, prod});

    assign first    = (tap_cnt == '0);
    assign last     = (tap_cnt == LAST);
    // Only the final tap of a group needs the output slot, so only it can stall.
    assign in_ready = !last || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst)
            tap_cnt <= '0;
        else if (accept)
            tap_cnt <= last ? '0 : tap_cnt + CW'(1);
    end

`ifdef MCM_SCHED_PIPE_EN
    logic                    s_valid, s_first, s_last;
    logic signed [ACC_W-1:0] s_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_first <= 1'b0;
            s_last  <= 1'b0;
            s_prod  <= '0;
        end else begin
            s_valid <= accept;
            if (accept) begin
                s_first <= first;
                s_last  <= last;
                s_prod  <= sprod;
            end
        end
    end

    assign a_valid    = s_valid;
    assign a_first    = s_first;
    assign a_last     = s_last;
    assign a_prod     = s_prod;
    assign stage_busy = s_valid;
`else
    assign a_valid    = accept;
    assign a_first    = first;
    assign a_last     = last;
    assign a_prod     = sprod;
    assign stage_busy = 1'b0;
`endif

    assign acc_next = a_first ? a_prod : acc + a_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_pix   <= '0;
        end else begin
            if (a_valid)
                acc <= acc_next;
            if (a_valid && a_last) begin
                out_pix   <= round_clip(acc_next, SHIFT);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (tap_cnt != '0) || stage_busy;

endmodule

// File: tb/tb_mcm_tap_sched.sv
// Scoreboard bench for mcm_tap_sched: directed tap groups, expected pixels queued at issue.
module tb_mcm_tap_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_sample;
    logic [5:0] in_cidx;
    logic       in_neg;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pix;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_acc = 0;
    logic [7:0] exp_q [$];
    int         hs_q [$];
    logic       stalled = 1'b0;
    logic [7:0] held = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mcm_tap_sched #(.NTAPS(4), .SHIFT(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .in_cidx   (in_cidx),
        .in_neg    (in_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change only at the falling edge; the monitor samples 2 time units later.
    task automatic send(input logic [7:0] s, input logic [5:0] c, input logic n);
        int w = 0;
        in_valid  = 1'b1;
        in_sample = s;
        in_cidx   = c;
        in_neg    = n;
        forever begin
            #1;
            if (in_ready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
            w++;
            if (w > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: tap not accepted after %0d cycles, expected acceptance", w);
                break;
            end
        end
        n_acc++;
    endtask

    task automatic send_group(input logic [7:0] s, input logic [5:0] c0, input logic [5:0] c1,
                              input logic [5:0] c2, input logic [5:0] c3, input logic [3:0] neg,
                              input logic [7:0] exp_pix);
        exp_q.push_back(exp_pix);
        send(s, c0, neg[0]);
        send(s, c1, neg[1]);
        send(s, c2, neg[2]);
        send(s, c3, neg[3]);
    endtask

    task automatic drain(input string name);
        int w = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check(name, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    check("pix_hold", out_pix, held);
                if (out_valid && out_ready) begin
                    hs_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pix: got pixel %0d, expected no pixel", out_pix);
                    end else begin
                        check("pix", out_pix, exp_q.pop_front());
                    end
                end
                stalled = out_valid && !out_ready;
                held    = out_pix;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        in_cidx   = '0;
        in_neg    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pix", out_pix, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // 1600 + 3100 - 6000 + 6400 = 5100 -> 80
        send_group(8'd100, 6'd24, 6'd33, 6'd3, 6'd0, 4'b0100, 8'd80);
        in_valid = 1'b0;
        #1;
`ifdef MCM_SCHED_PIPE_EN
        check("lat_t1", out_valid, 0);
        @(negedge clk);
        #1;
        check("lat_t2", out_valid, 1);
`else
        check("lat_t1", out_valid, 1);
`endif
        drain("drain_basic");

        send_group(8'd255, 6'd0, 6'd0, 6'd0, 6'd0, 4'b1111, 8'd0);
        send_group(8'd255, 6'd0, 6'd0, 6'd0, 6'd0, 4'b0000, 8'd255);
        send_group(8'd77, 6'd50, 6'd50, 6'd50, 6'd50, 4'b0101, 8'd0);
        send_group(8'd64, 6'd0, 6'd0, 6'd42, 6'd42, 4'b0000, 8'd128);
        drain("drain_extremes");

        // Output stalled for 10 cycles while three groups stream in.
        fork
            begin
                n_acc = 0;
                send_group(8'd10, 6'd0, 6'd0, 6'd0, 6'd0, 4'b0000, 8'd40);
                send_group(8'd20, 6'd0, 6'd0, 6'd0, 6'd0, 4'b0000, 8'd80);
                send_group(8'd30, 6'd0, 6'd0, 6'd0, 6'd0, 4'b0000, 8'd120);
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b0;
                repeat (9) @(negedge clk);
                #1;
                check("stall_in_ready", in_ready, 0);
                check("stall_taps_acc", n_acc, 7);
                @(negedge clk);
                out_ready = 1'b1;
`ifndef MCM_SCHED_PIPE_EN
                @(negedge clk);
                #1;
                check("no_bubble", out_valid, 1);
`endif
            end
        join
        drain("drain_stall");

        hs_q.delete();
        send_group(8'd40, 6'd0, 6'd0, 6'd0, 6'd0, 4'b0000, 8'd160);
        send_group(8'd50, 6'd0, 6'd0, 6'd0, 6'd0, 4'b0000, 8'd200);
        send_group(8'd60, 6'd0, 6'd0, 6'd0, 6'd0, 4'b0000, 8'd240);
        drain("drain_b2b");
        check("b2b_count", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            check("b2b_gap0", hs_q[1] - hs_q[0], 4);
            check("b2b_gap1", hs_q[2] - hs_q[1], 4);
        end

        // Reset after two taps, then reset coinciding with a final tap.
        send(8'd200, 6'd0, 1'b0);
        send(8'd200, 6'd0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        send(8'd200, 6'd0, 1'b0);
        send(8'd200, 6'd0, 1'b0);
        send(8'd200, 6'd0, 1'b0);
        in_valid  = 1'b1;
        in_sample = 8'd200;
        in_cidx   = 6'd0;
        rst       = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("finrst_out_valid", out_valid, 0);
        check("finrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        #1;
        check("finrst_quiet", out_valid, 0);
        @(negedge clk);
        send_group(8'd64, 6'd0, 6'd0, 6'd42, 6'd42, 4'b0000, 8'd128);
        drain("drain_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
